// File: rtl/lut_neuron_pkg.sv
// Shared types and helpers for the programmable LUT neuron layer.
//   state_e      : clear-FSM states (CLEAR sweeps every table to zero, RUN serves lookups)
//   calc_addr_w  : table address width from fan-in and bits per input
//   even_parity  : parity bit that makes the stored entry's total ones count even
package lut_neuron_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic int calc_addr_w(input int fanin, input int in_bits);
        return fanin * in_bits;
    endfunction

    function automatic logic even_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lut_neuron_layer_prog_table.sv
// One neuron's truth table: 2**ADDR_W x ENTRY_W distributed RAM.
// Ports:
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data (payload, plus parity bit on top when enabled)
//   raddr_i  : asynchronous read address
//   rdata_o  : asynchronous read data
// The read is combinational, so a same-edge write is seen by the next
// lookup only (the registered lookup captures the old value).
module lut_neuron_table #(
    parameter int ADDR_W  = 8,
    parameter int ENTRY_W = 2
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);
    localparam int DEPTH = 1 << ADDR_W;

    (* ram_style = "distributed" *) logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lut_neuron_layer_prog.sv
// Runtime-programmable layer of NUM_NEURONS LUT neurons.
// After reset (or cfg_clear) a hardware sweep zeroes every table entry,
// one address per cycle across all neurons, then the layer enters RUN.
// Lookups pass through a single valid/ready register stage.
// Optional macro LUT_PARITY_EN: each entry carries an even-parity bit and a
// sticky parity_err output flags any mismatch seen on a lookup.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : input handshake; in_data holds per-neuron addresses
//   out_valid/out_ready  : output handshake; out_data holds per-neuron results
//   cfg_we/cfg_neuron/cfg_addr/cfg_data : table write port (only while cfg_ready)
//   cfg_clear            : re-zero all tables
//   cfg_ready            : layer in RUN
//   busy                 : clear sweep in progress
//   parity_err           : sticky parity error (LUT_PARITY_EN only)
module lut_neuron_layer_prog
    import lut_neuron_pkg::*;
#(
    parameter  int NUM_NEURONS = 8,
    parameter  int FANIN       = 4,
    parameter  int IN_BITS     = 2,
    parameter  int OUT_BITS    = 2,
    localparam int ADDR_W      = calc_addr_w(FANIN, IN_BITS),
    localparam int NID_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_NEURONS*ADDR_W-1:0]   in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                            cfg_we,
    input  logic [NID_W-1:0]                cfg_neuron,
    input  logic [ADDR_W-1:0]               cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_data,
    input  logic                            cfg_clear,
    output logic                            cfg_ready,
`ifdef LUT_PARITY_EN
    output logic                            parity_err,
`endif
    output logic                            busy
);
    localparam int DEPTH = 1 << ADDR_W;
`ifdef LUT_PARITY_EN
    localparam int ENTRY_W = OUT_BITS + 1;
`else
    localparam int ENTRY_W = OUT_BITS;
`endif

    state_e                          state_q, state_d;
    logic [ADDR_W-1:0]               clr_cnt_q, clr_cnt_d;
    logic                            out_valid_q, out_valid_d;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
    logic [NUM_NEURONS*OUT_BITS-1:0] lookup;
    logic [ENTRY_W-1:0]              cfg_entry;
    logic                            clearing, accept;

    assign clearing  = (state_q == CLEAR);
    assign busy      = clearing;
    assign cfg_ready = (state_q == RUN);
    // A held output during CLEAR still drains via out_ready, but nothing new enters.
    assign in_ready  = cfg_ready && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef LUT_PARITY_EN
    logic [NUM_NEURONS-1:0] par_bad;
    assign cfg_entry = {even_parity(32'(cfg_data)), cfg_data};
`else
    assign cfg_entry = cfg_data;
`endif

    for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_nrn
        logic               we_k;
        logic [ADDR_W-1:0]  waddr_k;
        logic [ENTRY_W-1:0] wdata_k, rdata_k;

        // Clear sweep owns the write port; an all-zero entry already has even parity.
        // Out-of-range cfg_neuron never matches any k, so such writes drop.
        assign we_k    = clearing || (cfg_we && cfg_ready && (cfg_neuron == NID_W'(k)));
        assign waddr_k = clearing ? clr_cnt_q : cfg_addr;
        assign wdata_k = clearing ? '0 : cfg_entry;

        lut_neuron_table #(
            .ADDR_W  (ADDR_W),
            .ENTRY_W (ENTRY_W)
        ) u_tbl (
            .clk     (clk),
            .we_i    (we_k),
            .waddr_i (waddr_k),
            .wdata_i (wdata_k),
            .raddr_i (in_data[k*ADDR_W +: ADDR_W]),
            .rdata_o (rdata_k)
        );

        assign lookup[k*OUT_BITS +: OUT_BITS] = rdata_k[OUT_BITS-1:0];
`ifdef LUT_PARITY_EN
        assign par_bad[k] = ^rdata_k;
`endif
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                if (cfg_clear) begin
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            RUN: begin
                if (cfg_clear) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = lookup;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef LUT_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_comb begin
        parity_err_d = parity_err_q;
        if (cfg_clear)                parity_err_d = 1'b0;
        else if (accept && |par_bad)  parity_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err_q <= 1'b0;
        else        parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_lut_neuron_layer_prog.sv
// Self-checking bench for lut_neuron_layer_prog (default parameters).
// Directed table of writes/lookups, random traffic against a table model
// with an expected-output queue, plus clear/stall/reset sequences.
`timescale 1ns/1ps
module tb_lut_neuron_layer_prog;
    localparam int N  = 8;
    localparam int AW = 8;
    localparam int OB = 2;
    localparam int NW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0, out_ready = 1'b0, cfg_we = 1'b0, cfg_clear = 1'b0;
    logic [N*AW-1:0] in_data = '0;
    logic [NW-1:0]   cfg_neuron = '0;
    logic [AW-1:0]   cfg_addr = '0;
    logic [OB-1:0]   cfg_data = '0;
    logic            in_ready, out_valid, cfg_ready, busy;
    logic [N*OB-1:0] out_data;
`ifdef LUT_PARITY_EN
    logic            parity_err;
`endif

    lut_neuron_layer_prog dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_clear  (cfg_clear),
        .cfg_ready  (cfg_ready),
`ifdef LUT_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [OB-1:0]   mdl [N][1<<AW];
    logic [N*OB-1:0] exp_q [$];

    typedef struct {
        logic          we;
        logic [NW-1:0] nid;
        logic [AW-1:0] addr;
        logic [OB-1:0] dat;
        logic          iv;
        logic [AW-1:0] la;
        logic          ev;
        logic [N*OB-1:0] exp;
    } vec_t;
    vec_t tv [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++)
            for (int a = 0; a < (1 << AW); a++) mdl[k][a] = '0;
    endtask

    function automatic logic [N*OB-1:0] ref_lookup(input logic [N*AW-1:0] d);
        logic [N*OB-1:0] r;
        for (int k = 0; k < N; k++) r[k*OB +: OB] = mdl[k][d[k*AW +: AW]];
        return r;
    endfunction

    function automatic logic [N*AW-1:0] all_addr(input logic [AW-1:0] a);
        logic [N*AW-1:0] r;
        for (int k = 0; k < N; k++) r[k*AW +: AW] = a;
        return r;
    endfunction

    // Half the addresses come from a small window so programmed entries get hit.
    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, (1 << AW) - 1));
    endfunction

    function automatic logic [N*AW-1:0] rand_vec();
        logic [N*AW-1:0] r;
        for (int k = 0; k < N; k++) r[k*AW +: AW] = rand_addr();
        return r;
    endfunction

    task automatic wait_clear(input string name);
        int n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        chk(name, 64'(n), 64'd256);
        chk({name, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
    endtask

    // One clock of traffic scored against the model: accepted inputs push the
    // model's answer, output handshakes pop and compare, stalls must hold.
    task automatic sb_cycle(input logic iv, input logic [N*AW-1:0] d, input logic ordy,
                            input logic we, input logic [NW-1:0] nid,
                            input logic [AW-1:0] a, input logic [OB-1:0] v);
        logic            held_v, acc;
        logic [N*OB-1:0] held_d;
        in_valid = iv; in_data = d; out_ready = ordy;
        cfg_we = we; cfg_neuron = nid; cfg_addr = a; cfg_data = v;
        #1;
        chk("in_ready_rule", 64'(in_ready), 64'(cfg_ready && (!out_valid || ordy)));
        if (out_valid && ordy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
                chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
        acc = iv && in_ready;
        if (acc) exp_q.push_back(ref_lookup(d));
        if (we && cfg_ready) mdl[nid][a] = v;
        held_v = out_valid && !ordy;
        held_d = out_data;
        tick();
        if (acc) chk("latency_valid", 64'(out_valid), 64'd1);
        if (held_v) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'(held_d));
        end
    endtask

    initial begin
        logic [N*AW-1:0] v;
        logic [N*OB-1:0] held;
        int bad_ir, bad_hold, n;

        tv[0]  = '{1'b1, 3'd3, 8'h20, 2'b01, 1'b0, 8'h00, 1'b0, 16'h0000};
        tv[1]  = '{1'b1, 3'd3, 8'h30, 2'b01, 1'b0, 8'h00, 1'b0, 16'h0000};
        tv[2]  = '{1'b0, 3'd0, 8'h00, 2'b00, 1'b1, 8'h20, 1'b1, 16'h0040};
        tv[3]  = '{1'b0, 3'd0, 8'h00, 2'b00, 1'b1, 8'h60, 1'b1, 16'h0000};
        tv[4]  = '{1'b0, 3'd0, 8'h00, 2'b00, 1'b1, 8'h30, 1'b1, 16'h0040};
        tv[5]  = '{1'b1, 3'd3, 8'h20, 2'b10, 1'b1, 8'h20, 1'b1, 16'h0040};
        tv[6]  = '{1'b0, 3'd0, 8'h00, 2'b00, 1'b1, 8'h20, 1'b1, 16'h0080};
        tv[7]  = '{1'b1, 3'd5, 8'h20, 2'b11, 1'b0, 8'h00, 1'b0, 16'h0000};
        tv[8]  = '{1'b0, 3'd0, 8'h00, 2'b00, 1'b1, 8'h20, 1'b1, 16'h0C80};
        tv[9]  = '{1'b0, 3'd0, 8'h00, 2'b00, 1'b1, 8'h30, 1'b1, 16'h0040};
        tv[10] = '{1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 16'h0000};

        // Reset state
        #1 rst_n = 1'b0;
        #3;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        #8 rst_n = 1'b1;
        model_clear();
        wait_clear("reset_clear_cycles");

        // Everything reads zero after the sweep
        in_valid = 1'b1; in_data = rand_vec(); out_ready = 1'b1;
        tick();
        chk("post_reset_valid", 64'(out_valid), 64'd1);
        chk("post_reset_zero", 64'(out_data), 64'd0);

        // Directed table: programming, back-to-back stream, read-before-write
        for (int i = 0; i < 11; i++) begin
            cfg_we = tv[i].we; cfg_neuron = tv[i].nid; cfg_addr = tv[i].addr; cfg_data = tv[i].dat;
            in_valid = tv[i].iv; in_data = all_addr(tv[i].la); out_ready = 1'b1;
            if (tv[i].we) mdl[tv[i].nid][tv[i].addr] = tv[i].dat;
            tick();
            chk($sformatf("tv%0d_valid", i), 64'(out_valid), 64'(tv[i].ev));
            if (tv[i].ev) chk($sformatf("tv%0d_data", i), 64'(out_data), 64'(tv[i].exp));
        end

        // Stall: in_valid held with out_ready low for 5 cycles
        sb_cycle(1'b1, all_addr(8'h20), 1'b0, 1'b0, '0, '0, '0);
        v = all_addr(8'h30);
        for (int i = 0; i < 5; i++) begin
            sb_cycle(1'b1, v, 1'b0, 1'b0, '0, '0, '0);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        sb_cycle(1'b1, v, 1'b1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 2; i++) sb_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, '0);
        chk("stall_drained", 64'(exp_q.size()), 64'd0);

        // Random traffic with random backpressure and config writes
        for (int i = 0; i < 400; i++)
            sb_cycle($urandom_range(0, 3) != 0, rand_vec(), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) == 0, NW'($urandom_range(0, N - 1)),
                     rand_addr(), OB'($urandom_range(0, 3)));
        for (int i = 0; i < 3; i++) sb_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, '0);
        chk("random_drained", 64'(exp_q.size()), 64'd0);

        // cfg_clear while an output is held
        sb_cycle(1'b1, all_addr(8'h20), 1'b0, 1'b0, '0, '0, '0);
        held = exp_q[0];
        cfg_clear = 1'b1; in_valid = 1'b1; in_data = rand_vec(); out_ready = 1'b0; cfg_we = 1'b0;
        tick();
        cfg_clear = 1'b0;
        chk("clear_busy", 64'(busy), 64'd1);
        bad_ir = 0; bad_hold = 0; n = 0;
        while (busy && n < 1000) begin
            if (in_ready) bad_ir++;
            if (!out_valid || out_data !== held) bad_hold++;
            tick();
            n++;
        end
        chk("clear_cycles", 64'(n), 64'd256);
        chk("clear_no_accept", 64'(bad_ir), 64'd0);
        chk("clear_hold_errs", 64'(bad_hold), 64'd0);
        model_clear();
        sb_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, '0);
        sb_cycle(1'b1, all_addr(8'h20), 1'b1, 1'b0, '0, '0, '0);
        chk("post_clear_zero", 64'(out_data), 64'd0);
        sb_cycle(1'b1, rand_vec(), 1'b1, 1'b0, '0, '0, '0);
        sb_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, '0);
        chk("clear_drained", 64'(exp_q.size()), 64'd0);

        // Async reset mid-stream
        sb_cycle(1'b1, rand_vec(), 1'b0, 1'b0, '0, '0, '0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd1);
        exp_q.delete();
        model_clear();
        rst_n = 1'b1;
        in_valid = 1'b0;
        wait_clear("rerst_clear_cycles");
        sb_cycle(1'b1, rand_vec(), 1'b1, 1'b0, '0, '0, '0);
        chk("post_rerst_zero", 64'(out_data), 64'd0);
        sb_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, '0);

`ifdef LUT_PARITY_EN
        chk("parity_clean", 64'(parity_err), 64'd0);
        dut.g_nrn[0].u_tbl.mem_q[5][OB] = ~dut.g_nrn[0].u_tbl.mem_q[5][OB];
        sb_cycle(1'b1, all_addr(8'h05), 1'b1, 1'b0, '0, '0, '0);
        chk("parity_set", 64'(parity_err), 64'd1);
        sb_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, '0);
        sb_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, '0);
        chk("parity_sticky", 64'(parity_err), 64'd1);
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        chk("parity_cleared", 64'(parity_err), 64'd0);
        wait_clear("parity_clear_cycles");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lut_neuron_layer_prog.md
Name: lut_neuron_layer_prog

Overview:
- Parametrised, runtime-programmable successor to the fixed-ROM LUT neuron.
- Holds NUM_NEURONS truth tables, each indexed by FANIN*IN_BITS quantised input bits and returning OUT_BITS.
- Tables are loaded through a config port and cleared by a hardware state machine after reset.
- Lookups flow through a one-stage valid/ready pipeline. Sits between quantised activation layers of a LogicNets-style network.

Parameters:
- NUM_NEURONS, 8, neurons (tables) in the layer.
- FANIN, 4, inputs per neuron.
- IN_BITS, 2, bits per input.
- OUT_BITS, 2, bits per neuron output.
- ADDR_W, FANIN*IN_BITS (derived, localparam), table address width; table depth 2**ADDR_W.
- NID_W, $clog2(NUM_NEURONS) (derived, min 1), neuron-select width.

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Asynchronous active-low reset.
- in_valid  in  1  Input vector valid.
- in_ready  out  1  Layer accepts input.
- in_data  in  NUM_NEURONS*ADDR_W  Per-neuron pre-wired table addresses; neuron k occupies bits [k*ADDR_W +: ADDR_W].
- out_valid  out  1  Output vector valid.
- out_ready  in  1  Downstream accepts output.
- out_data  out  NUM_NEURONS*OUT_BITS  Neuron k result at [k*OUT_BITS +: OUT_BITS].
- cfg_we  in  1  Table write strobe.
- cfg_neuron  in  NID_W  Target neuron.
- cfg_addr  in  ADDR_W  Target entry.
- cfg_data  in  OUT_BITS  Entry value.
- cfg_clear  in  1  Pulse: re-zero all tables.
- cfg_ready  out  1  High when in RUN; writes accepted only when high.
- busy  out  1  High while in CLEAR.

Behaviour:
- Reset (async assert, sync release): state=CLEAR, clr_cnt=0, out_valid=0, out_data=0, in_ready=0, cfg_ready=0, busy=1.
- States:
  - CLEAR: each cycle writes 0 to entry clr_cnt in all neurons; clr_cnt increments; at clr_cnt==2**ADDR_W-1, go to RUN next cycle. Duration exactly 2**ADDR_W cycles (256 at defaults).
  - RUN: normal operation. cfg_clear in RUN → CLEAR, clr_cnt=0.
- cfg_clear in CLEAR: restarts the count from 0.
- in_ready = (state==RUN) && (!out_valid || out_ready). Combinational; no combinational in_valid→out_valid path.
- Transfer on in_valid&&in_ready: next cycle out_valid=1 and out_data = table[k][in_data slice k] for all k. Latency 1 cycle.
- out_valid/out_data stay stable while out_valid&&!out_ready.
- out_valid drops after an out_ready handshake with no new input.
- Full throughput: one vector per cycle when out_ready=1.
- Config writes: cfg_we&&cfg_ready writes the entry at the clock edge. cfg_we with cfg_ready=0 is ignored, with no error.
- cfg_neuron >= NUM_NEURONS: write ignored.
- Simultaneous lookup and write to the same neuron/entry: lookup returns the old value (read-before-write).
- Entering CLEAR while out_valid=1: the held output is preserved until consumed; no new inputs are accepted until RUN.
- Async reset mid-transfer: the in-flight output is discarded and tables are re-cleared.
- Storage: distributed RAM, rom_style/ram_style "distributed", one read port per neuron plus the shared write port.

Optional Feature:
- LUT_PARITY_EN defined:
  - Each entry stores an extra even-parity bit, computed on write (parity of 0 during CLEAR).
  - On every lookup the parity is checked; any mismatch sets a sticky output parity_err (1 bit), which clears only on reset or cfg_clear.
  - The parity_err port exists only under this macro.
- Undefined: no parity storage, no port.

Decomposition:
- Package lut_neuron_pkg:
  - state enum {CLEAR, RUN};
  - function computing ADDR_W from FANIN/IN_BITS;
  - parity function.
- Sub-module lut_neuron_table: one neuron's 2**ADDR_W x OUT_BITS(+parity) distributed RAM, with async read and sync write. The top generates NUM_NEURONS instances plus the clear FSM and pipeline register.

Test Plan:
- Reset then idle → busy=1 for exactly 256 cycles, cfg_ready rises on cycle 256, and a lookup of any address returns 0 on all neurons.
- Program neuron 3 entry 8'h20 = 2'b01 and entry 8'h30 = 2'b01; stream in_data with neuron 3 address 8'h20, 8'h60, 8'h30 → out slice 3 = 01, 00, 01, one cycle after each accept, back-to-back.
- Hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 after the first accept, out_data stable, and no input lost once out_ready=1.
- Same-cycle write entry 8'h20 = 2'b10 and lookup 8'h20 on neuron 3 → output 01; the next lookup returns 10.
- cfg_clear while out_valid=1 and out_ready=0 → held output is preserved, busy=1 for 256 cycles, and afterwards all entries read 0. Asserting rst_n=0 mid-stream drops out_valid asynchronously.
- With LUT_PARITY_EN defined: force (via backdoor) a parity flip on neuron 0 entry 5, look up address 5 → parity_err=1 and it stays set until cfg_clear.
